state2_drv: RTL and testbench

STATE2_DRV -- requirements
Module: state2_drv

---
 rtl/state2_drv.sv | 237 +++++++++++++++++++++++
 tb/tb_state2_drv.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state2_drv.sv
// state2_drv: sequence driver and checker for a small controlled FSM.
//
// Drives registered stimulus {i1,i2} into the controlled FSM one step per
// cycle and compares the observed {o1,o2,err} against the expected value
// for each step. The controlled FSM's outputs are registered, so step k
// (driven at edge k) is checked at edge k+2 through a 2-deep pipeline.
//
// Ports:
//   clk        rising-edge clock
//   nrst       synchronous active-low reset
//   start      command strobe, taken only in IDLE
//   mode       00 loop, 01 error-inject, 10 recovery, 11 illegal
//   loops      repetition count for modes 00/10 (ignored in mode 01)
//   abort      terminate the running sequence (ignored while not busy)
//   o1,o2,err  observed outputs of the controlled FSM
//   i1,i2      registered stimulus to the controlled FSM
//   busy       sequence in progress (RUN or DRAIN)
//   done       one-cycle completion pulse (DONE state)
//   fail_code  00 pass, 01 precondition, 10 mismatch, 11 abort/illegal
//   fail_step  index of the first mismatching step (valid for code 10)
//   dbg_state  current driver state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//
// Command semantics: start is a strobe, not a handshake. It is sampled only
// while the driver is in IDLE; start while busy (or in the DONE cycle) is
// dropped. busy and done are decoded from the state register, so busy falls
// on the same edge that done rises.
module state2_drv #(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [LW-1:0] loops,
    input  logic          abort,
    input  logic          o1,
    input  logic          o2,
    input  logic          err,
    output logic          i1,
    output logic          i2,
    output logic          busy,
    output logic          done,
    output logic [1:0]    fail_code,
    output logic [5:0]    fail_step,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One pending compare: expected {o1,o2,err} and the step it belongs to.
    typedef struct packed {
        logic       vld;
        logic [2:0] exp;
        logic [5:0] idx;
    } pipe_t;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [5:0] total_q, total_d;
    logic [5:0] step_q, step_d;
    logic [1:0] phase_q, phase_d;
    logic [1:0] i_q, i_d;
    pipe_t      p0_q, p0_d;
    pipe_t      p1_q, p1_d;
    logic [1:0] fcode_q, fcode_d;
    logic [5:0] fstep_q, fstep_d;

    logic [2:0]    obs;
    logic [LW+1:0] loops_x;
    logic [5:0]    tot;
    logic [1:0]    last_phase;
    logic [4:0]    cur_step;
    logic [4:0]    first_step;
    logic          mismatch;
    logic          pending;

    assign obs     = {o1, o2, err};
    assign loops_x = {2'b00, loops};

    // Step table, returns {i1,i2, expected o1,o2,err}.
    function automatic logic [4:0] step_of(input logic [1:0] m, input logic [1:0] ph);
        logic [4:0] r;
        case ({m, ph})
            4'b00_00: r = 5'b11_100;
            4'b00_01: r = 5'b11_010;
            4'b00_10: r = 5'b10_000;
            4'b01_00: r = 5'b10_111;
            4'b01_01: r = 5'b10_111;
            4'b01_10: r = 5'b00_000;
            4'b10_00: r = 5'b11_100;
            4'b10_01: r = 5'b11_010;
            4'b10_10: r = 5'b00_111;
            4'b10_11: r = 5'b00_000;
            default:  r = 5'b00_000;
        endcase
        return r;
    endfunction

    // Total number of steps for the requested sequence.
    always_comb begin
        case (mode)
            2'b10:   tot = 6'(loops_x << 2);
            2'b01:   tot = 6'd3;
            default: tot = 6'(loops_x + (loops_x << 1));
        endcase
    end

    assign last_phase = (mode_q == 2'b10) ? 2'd3 : 2'd2;
    assign cur_step   = step_of(mode_q, phase_q);
    assign first_step = step_of(mode, 2'd0);
    assign mismatch   = p1_q.vld && (obs != p1_q.exp);
    // Abort only matters while a sequence still has work outstanding; the
    // wait cycle after an early termination is not abortable.
    assign pending    = (state_q == ST_RUN) || p0_q.vld || p1_q.vld;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        total_d = total_q;
        step_d  = step_q;
        phase_d = phase_q;
        i_d     = i_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        fcode_d = fcode_q;
        fstep_d = fstep_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    fstep_d = 6'd0;
                    p0_d    = '0;
                    p1_d    = '0;
                    i_d     = 2'b00;
                    // Early exits go through an empty DRAIN so done lands
                    // exactly one cycle after the start edge.
                    if (mode == 2'b11) begin
                        fcode_d = 2'b11;
                        state_d = ST_DRAIN;
                    end else if (obs != 3'b000) begin
                        fcode_d = 2'b01;
                        state_d = ST_DRAIN;
                    end else if ((mode != 2'b01) && (loops == '0)) begin
                        fcode_d = 2'b00;
                        state_d = ST_DRAIN;
                    end else begin
                        fcode_d = 2'b00;
                        total_d = tot;
                        i_d     = first_step[4:3];
                        p0_d    = '{vld: 1'b1, exp: first_step[2:0], idx: 6'd0};
                        step_d  = 6'd1;
                        phase_d = 2'd1;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN, ST_DRAIN: begin
                p1_d = p0_q;
                p0_d = '0;
                if (mismatch) begin
                    fcode_d = 2'b10;
                    fstep_d = p1_q.idx;
                    i_d     = 2'b00;
                    p1_d    = '0;
                    state_d = ST_DRAIN;
                end else if (abort && pending) begin
                    fcode_d = 2'b11;
                    i_d     = 2'b00;
                    p1_d    = '0;
                    state_d = ST_DRAIN;
                end else if (state_q == ST_RUN) begin
                    if (step_q == total_q) begin
                        i_d     = 2'b00;
                        state_d = ST_DRAIN;
                    end else begin
                        i_d     = cur_step[4:3];
                        p0_d    = '{vld: 1'b1, exp: cur_step[2:0], idx: step_q};
                        step_d  = step_q + 6'd1;
                        phase_d = (phase_q == last_phase) ? 2'd0 : phase_q + 2'd1;
                    end
                end else if (!p0_q.vld && !p1_q.vld) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'b00;
            total_q <= 6'd0;
            step_q  <= 6'd0;
            phase_q <= 2'd0;
            i_q     <= 2'b00;
            p0_q    <= '0;
            p1_q    <= '0;
            fcode_q <= 2'b00;
            fstep_q <= 6'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            total_q <= total_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            i_q     <= i_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            fcode_q <= fcode_d;
            fstep_q <= fstep_d;
        end
    end

    assign i1        = i_q[1];
    assign i2        = i_q[0];
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign fail_code = fcode_q;
    assign fail_step = fstep_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_state2_drv.sv
// Directed testbench for state2_drv. Contains a behavioural model of the
// controlled FSM (with hooks to preload its state or pin it in S1) and one
// task per scenario.
module tb_state2_drv;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] loops = 4'd0;
    logic       o1, o2, err;
    logic       i1, i2, busy, done;
    logic [1:0] fail_code;
    logic [5:0] fail_step;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Controlled FSM model, state held as its output code {o1,o2,err}.
    logic [2:0] m_q = 3'b000;
    logic       mdl_ld = 1'b0;
    logic [2:0] mdl_val = 3'b000;
    logic       hold_s1 = 1'b0;

    always #5 clk = ~clk;

    state2_drv #(.LW(4)) dut (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode), .loops(loops),
        .abort(abort), .o1(o1), .o2(o2), .err(err), .i1(i1), .i2(i2),
        .busy(busy), .done(done), .fail_code(fail_code), .fail_step(fail_step),
        .dbg_state(dbg_state)
    );

    always @(posedge clk) begin
        if (mdl_ld) begin
            m_q <= mdl_val;
        end else begin
            case (m_q)
                3'b000: if (i1 && i2) m_q <= 3'b100; else if (i1 && !i2) m_q <= 3'b111;
                3'b100: if (i1 && i2) begin
                            if (!hold_s1) m_q <= 3'b010;
                        end else if (!i1 && i2) m_q <= 3'b111;
                3'b010: if (i1 && !i2) m_q <= 3'b000; else if (!i1 && !i2) m_q <= 3'b111;
                3'b111: if (!i1) m_q <= 3'b000;
                default: m_q <= 3'b000;
            endcase
        end
    end
    assign {o1, o2, err} = m_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_force(input logic [2:0] v);
        mdl_ld = 1'b1;
        mdl_val = v;
        tick();
        mdl_ld = 1'b0;
    endtask

    // Leaves the bench just after the accept edge (edge 0).
    task automatic start_seq(input logic [1:0] m, input logic [3:0] l);
        start = 1'b1;
        mode = m;
        loops = l;
        tick();
        start = 1'b0;
    endtask

    // Returns number of edges until done is seen, or -1 on timeout.
    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (done === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        n_cmp++; if ({i1, i2} !== 2'b00) begin n_bad++; $display("FAIL reset_i got %b want 00", {i1, i2}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL reset_code got %b want 00", fail_code); end
        n_cmp++; if (fail_step !== 6'd0) begin n_bad++; $display("FAIL reset_step got %0d want 0", fail_step); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_loop();
        logic [1:0] exp_i [0:6];
        int n;
        exp_i = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
        mdl_force(3'b000);
        start_seq(2'b00, 4'd2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL loop_busy got %b want 1", busy); end
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            n_cmp++; if ({i1, i2} !== exp_i[k]) begin n_bad++; $display("FAIL loop_i edge%0d got %b want %b", k, {i1, i2}, exp_i[k]); end
        end
        wait_done(10, n);
        n_cmp++; if (6 + n !== 8) begin n_bad++; $display("FAIL loop_done_edge got %0d want 8", 6 + n); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL loop_code got %b want 00", fail_code); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL loop_busy_end got %b want 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL loop_done_pulse got %b want 0", done); end
    endtask

    task automatic test_err_inject();
        logic [1:0] exp_i [0:3];
        logic [2:0] exp_o [1:3];
        int n;
        exp_i = '{2'b10, 2'b10, 2'b00, 2'b00};
        exp_o = '{3'b111, 3'b111, 3'b000};
        mdl_force(3'b000);
        start_seq(2'b01, 4'd9);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            n_cmp++; if ({i1, i2} !== exp_i[k]) begin n_bad++; $display("FAIL inj_i edge%0d got %b want %b", k, {i1, i2}, exp_i[k]); end
            if (k > 0) begin
                n_cmp++; if ({o1, o2, err} !== exp_o[k]) begin n_bad++; $display("FAIL inj_obs edge%0d got %b want %b", k, {o1, o2, err}, exp_o[k]); end
            end
        end
        wait_done(10, n);
        n_cmp++; if (3 + n !== 5) begin n_bad++; $display("FAIL inj_done_edge got %0d want 5", 3 + n); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL inj_code got %b want 00", fail_code); end
        tick();
    endtask

    // FSM pinned in S1 on step 1; abort lands on the mismatch edge too.
    task automatic test_mismatch();
        int n;
        mdl_force(3'b000);
        hold_s1 = 1'b1;
        start_seq(2'b10, 4'd1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if (fail_code !== 2'b10) begin n_bad++; $display("FAIL mm_code got %b want 10", fail_code); end
        n_cmp++; if (fail_step !== 6'd1) begin n_bad++; $display("FAIL mm_step got %0d want 1", fail_step); end
        n_cmp++; if ({i1, i2} !== 2'b00) begin n_bad++; $display("FAIL mm_i got %b want 00", {i1, i2}); end
        wait_done(10, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL mm_done_lat got %0d want 1", n); end
        n_cmp++; if (fail_code !== 2'b10) begin n_bad++; $display("FAIL mm_code_done got %b want 10", fail_code); end
        hold_s1 = 1'b0;
        tick();
        mdl_force(3'b000);
    endtask

    task automatic test_precond();
        int n;
        mdl_force(3'b100);
        start_seq(2'b00, 4'd2);
        n_cmp++; if ({i1, i2} !== 2'b00) begin n_bad++; $display("FAIL pre_i0 got %b want 00", {i1, i2}); end
        wait_done(5, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL pre_done_lat got %0d want 1", n); end
        n_cmp++; if ({i1, i2} !== 2'b00) begin n_bad++; $display("FAIL pre_i1 got %b want 00", {i1, i2}); end
        n_cmp++; if (fail_code !== 2'b01) begin n_bad++; $display("FAIL pre_code got %b want 01", fail_code); end
        tick();
        mdl_force(3'b000);
    endtask

    task automatic test_illegal_and_zero();
        int n;
        start_seq(2'b11, 4'd2);
        n_cmp++; if ({i1, i2} !== 2'b00) begin n_bad++; $display("FAIL ill_i got %b want 00", {i1, i2}); end
        wait_done(5, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL ill_done_lat got %0d want 1", n); end
        n_cmp++; if (fail_code !== 2'b11) begin n_bad++; $display("FAIL ill_code got %b want 11", fail_code); end
        tick();
        start_seq(2'b00, 4'd0);
        wait_done(5, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL zero_done_lat got %0d want 1", n); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL zero_code got %b want 00", fail_code); end
        n_cmp++; if ({i1, i2} !== 2'b00) begin n_bad++; $display("FAIL zero_i got %b want 00", {i1, i2}); end
        tick();
    endtask

    task automatic test_abort();
        int n;
        mdl_force(3'b000);
        start_seq(2'b00, 4'd3);
        tick();
        tick();
        n_cmp++; if ({i1, i2} !== 2'b10) begin n_bad++; $display("FAIL ab_i2 got %b want 10", {i1, i2}); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if ({i1, i2} !== 2'b00) begin n_bad++; $display("FAIL ab_i got %b want 00", {i1, i2}); end
        n_cmp++; if (fail_code !== 2'b11) begin n_bad++; $display("FAIL ab_code got %b want 11", fail_code); end
        wait_done(5, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL ab_done_lat got %0d want 1", n); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_busy got %b want 0", busy); end
        tick();
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        n_cmp++; if (fail_code !== 2'b11) begin n_bad++; $display("FAIL ab_idle_code got %b want 11", fail_code); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        mdl_force(3'b000);
        start_seq(2'b00, 4'd1);
        start = 1'b1;
        mode = 2'b11;
        tick();
        start = 1'b0;
        mode = 2'b00;
        n_cmp++; if ({i1, i2} !== 2'b11) begin n_bad++; $display("FAIL b2b_i1 got %b want 11", {i1, i2}); end
        wait_done(10, n);
        n_cmp++; if (1 + n !== 5) begin n_bad++; $display("FAIL b2b_done_edge got %0d want 5", 1 + n); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL b2b_code got %b want 00", fail_code); end
        tick();
        start_seq(2'b01, 4'd0);
        n_cmp++; if ({i1, i2} !== 2'b10) begin n_bad++; $display("FAIL b2b_i2 got %b want 10", {i1, i2}); end
        wait_done(10, n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL b2b_done2_edge got %0d want 5", n); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL b2b_code2 got %b want 00", fail_code); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        mdl_force(3'b000);
        start_seq(2'b10, 4'd3);
        tick();
        tick();
        nrst = 1'b0;
        tick();
        n_cmp++; if ({i1, i2, busy, done} !== 4'b0000) begin n_bad++; $display("FAIL rmid_outs got %b want 0000", {i1, i2, busy, done}); end
        n_cmp++; if ({fail_code, fail_step} !== 8'd0) begin n_bad++; $display("FAIL rmid_fail got %b want 0", {fail_code, fail_step}); end
        nrst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done got %b want 0", seen); end
        mdl_force(3'b000);
        start_seq(2'b10, 4'd1);
        wait_done(12, n);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL rmid_done_edge got %0d want 6", n); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL rmid_code got %b want 00", fail_code); end
        tick();
    endtask

    task automatic test_max_loops();
        int n;
        mdl_force(3'b000);
        start_seq(2'b10, 4'd15);
        wait_done(80, n);
        n_cmp++; if (n !== 62) begin n_bad++; $display("FAIL max_done_edge got %0d want 62", n); end
        n_cmp++; if (fail_code !== 2'b00) begin n_bad++; $display("FAIL max_code got %b want 00", fail_code); end
        tick();
    endtask

    initial begin
        test_reset();
        test_loop();
        test_err_inject();
        test_mismatch();
        test_precond();
        test_illegal_and_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_max_loops();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
